psram_line_master: RTL and testbench
====================================

Name: psram_line_master

Overview:
- Application-side initiator for the CellularRAM controller's app_* request/response interface.
- Accepts one command at a time from a client: either a burst read of 1..128 words into an internal line buffer, or a single-word write.
- Drives the controller's app_rd/app_wr/app_burst_op handshake and consumes app_op_begun, app_data_ok and op_finished.
- Sits between the controller and framebuffer/pixel logic; all logic runs on clk_100.

Parameters:
BUF_DEPTH, 128, line buffer words; the maximum burst length.
TIMEOUT, 1023, clk_100 cycles allowed from app_op_begun to op_finished before the operation is aborted.

Ports:
clk_100  in  1  system clock, 100MHz, same clock as the controller FSM
reset_n  in  1  asynchronous, active-low reset
app_ctrlr_good  in  1  controller ready; no request is issued before this is 1
app_op_begun  in  1  controller accepted the request (1-cycle pulse)
app_data_ok  in  1  data phase strobe (two cycles per memory word)
op_finished  in  1  operation complete (1-cycle pulse)
app_data_out  in  16  read data from controller
app_addr  out  23  request address
app_data_in  out  16  write data
app_rd  out  1  read request
app_wr  out  1  write request
app_ub  out  1  upper byte enable
app_lb  out  1  lower byte enable
app_burst_op  out  1  continue burst
cmd_valid  in  1  client command strobe
cmd_ready  out  1  block can accept a command
cmd_rd  in  1  1 = burst read, 0 = single write
cmd_addr  in  23  start address
cmd_len  in  8  read length; 0 is treated as 1, values above BUF_DEPTH are clipped to BUF_DEPTH
cmd_wdata  in  16  write data
cmd_ub  in  1  write upper byte enable
cmd_lb  in  1  write lower byte enable
buf_idx  in  7  line buffer read index
buf_word  out  16  line buffer word, registered, 1-cycle latency
rd_count  out  8  words captured by the last read
done  out  1  1-cycle pulse when a command completes
err  out  1  sticky timeout flag; cleared by the next accepted command

Behaviour:
- Reset values: all outputs 0, except that app_addr, app_data_in and buf_word are also 0. Line buffer contents are undefined after reset.
- States: WAIT_GOOD, IDLE, REQ, DATA, FIN, DONE.

State transitions:
- WAIT_GOOD -> IDLE when app_ctrlr_good=1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr/len/wdata/ub/lb, clear err, go to REQ.
  - Read: app_ub=app_lb=1.
  - Write: app_ub/app_lb take the command's enables.
- REQ:
  - Hold app_rd (read) or app_wr (write) at 1, with app_addr stable, until app_op_begun is sampled 1. Drop the strobe in the next cycle.
  - app_burst_op is set in the cycle after op_begun to (len>1) for reads, and is always 0 for writes.
  - Read -> DATA; write -> FIN.
- DATA:
  - A phase bit is cleared at op_begun and toggles on every app_data_ok cycle.
  - app_data_out is captured on app_data_ok with phase=0 into buffer[wptr]; wptr increments.
  - On capture of word len-1, app_burst_op clears in the following cycle. It is therefore 0 during that word's second app_data_ok cycle.
  - On op_finished -> DONE.
- FIN: on op_finished -> DONE.
- DONE: done=1 for 1 cycle, rd_count=wptr (0 for writes) -> IDLE.

Timeout and abort:
- A cycle counter starts at app_op_begun.
- If TIMEOUT is reached in DATA or FIN: err=1, done pulses, app_burst_op=0, return to IDLE.
- cmd_valid is ignored outside IDLE.

Boundary conditions:
- A capture attempt with wptr=BUF_DEPTH is dropped; the count saturates.
- op_finished arriving before len words: rd_count reports the words actually captured, and err stays 0.
- app_ctrlr_good falling while in IDLE -> WAIT_GOOD.
- Reset mid-operation: all request strobes deassert immediately (asynchronously).
- Line buffer port: read-only, 1-cycle latency. A buffer read and a capture to the same index in the same cycle returns the old data.

Test Plan:
- Reset held, then released with app_ctrlr_good=0 -> cmd_ready=0; set good=1 -> cmd_ready=1 next cycle, all app_* outputs 0.
- Write cmd (addr=0x12345, wdata=0xBEEF, ub=1, lb=0); model begins 3 cycles later -> app_wr high exactly until op_begun, app_burst_op=0; done pulses 1 cycle after op_finished; rd_count=0.
- Read len=4 from 0x100, model drives data 0xA0..0xA3 on paired data_ok -> buffer[0..3]=A0..A3, app_burst_op=0 during word 3's second strobe, rd_count=4.
- Read len=0 -> single word, app_burst_op stays 0; read len=200 -> 128 words captured, rd_count=128.
- Model never asserts op_finished -> err=1 and done after TIMEOUT cycles; next command clears err.
- reset_n asserted mid-burst read (word 2) -> app_rd/app_burst_op=0 immediately; after release, state is WAIT_GOOD, then a fresh len=2 read completes correctly.

Source files
------------

// File: rtl/psram_line_master.sv
// Client-side initiator for the CellularRAM controller app_* interface: one command
// at a time, either a burst read (1..BUF_DEPTH words) into a line buffer or a single-word write.
module psram_line_master #(
  parameter int BUF_DEPTH = 128,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        app_ctrlr_good,
  input  logic        app_op_begun,
  input  logic        app_data_ok,
  input  logic        op_finished,
  input  logic [15:0] app_data_out,
  output logic [22:0] app_addr,
  output logic [15:0] app_data_in,
  output logic        app_rd,
  output logic        app_wr,
  output logic        app_ub,
  output logic        app_lb,
  output logic        app_burst_op,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [22:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] cmd_wdata,
  input  logic        cmd_ub,
  input  logic        cmd_lb,
  input  logic [6:0]  buf_idx,
  output logic [15:0] buf_word,
  output logic [7:0]  rd_count,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int          AW       = $clog2(BUF_DEPTH);
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  DEPTH8   = 8'(BUF_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_WAIT_GOOD = 3'd0,
    S_IDLE      = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_FIN       = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e        state_q;
  logic [22:0]   app_addr_q;
  logic [15:0]   app_data_in_q;
  logic          app_rd_q, app_wr_q, app_ub_q, app_lb_q, app_burst_op_q;
  logic          cmd_ready_q, done_q, err_q, rd_q, phase_q;
  logic [7:0]    len_q, wptr_q, rd_count_q;
  logic [TW-1:0] tmo_q;
  logic [15:0]   buf_word_q;
  logic [15:0]   mem [BUF_DEPTH];

  logic [7:0]    len_eff;
  logic          cap_en, cap_last, tmo_hit;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == 8'd0)        len_eff = 8'd1;
    else if (cmd_len > DEPTH8)  len_eff = DEPTH8;
  end

  // A memory word arrives as two app_data_ok cycles; only the first one is captured.
  assign cap_en   = (state_q == S_DATA) && app_data_ok && !phase_q && (wptr_q < DEPTH8);
  assign cap_last = cap_en && (wptr_q == len_q - 8'd1);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // Client handshake: a command transfers on a clk_100 edge where cmd_valid && cmd_ready;
  // cmd_ready is registered, is 1 only in IDLE, and drops the cycle after a transfer.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_WAIT_GOOD;
      app_addr_q     <= '0;
      app_data_in_q  <= '0;
      app_rd_q       <= 1'b0;
      app_wr_q       <= 1'b0;
      app_ub_q       <= 1'b0;
      app_lb_q       <= 1'b0;
      app_burst_op_q <= 1'b0;
      cmd_ready_q    <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      rd_q           <= 1'b0;
      phase_q        <= 1'b0;
      len_q          <= '0;
      wptr_q         <= '0;
      rd_count_q     <= '0;
      tmo_q          <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_WAIT_GOOD: begin
          if (app_ctrlr_good) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            state_q       <= S_REQ;
            cmd_ready_q   <= 1'b0;
            err_q         <= 1'b0;
            rd_q          <= cmd_rd;
            app_rd_q      <= cmd_rd;
            app_wr_q      <= !cmd_rd;
            app_ub_q      <= cmd_rd | cmd_ub;
            app_lb_q      <= cmd_rd | cmd_lb;
            app_addr_q    <= cmd_addr;
            app_data_in_q <= cmd_wdata;
            len_q         <= len_eff;
            wptr_q        <= '0;
          end else if (!app_ctrlr_good) begin
            state_q     <= S_WAIT_GOOD;
            cmd_ready_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (app_op_begun) begin
            app_rd_q       <= 1'b0;
            app_wr_q       <= 1'b0;
            app_burst_op_q <= rd_q && (len_q > 8'd1);
            tmo_q          <= '0;
            phase_q        <= 1'b0;
            state_q        <= rd_q ? S_DATA : S_FIN;
          end
        end
        S_DATA, S_FIN: begin
          tmo_q <= tmo_q + TW'(1);
          if (state_q == S_DATA) begin
            if (app_data_ok) phase_q <= !phase_q;
            if (cap_en)      wptr_q  <= wptr_q + 8'd1;
            if (cap_last)    app_burst_op_q <= 1'b0;
          end
          if (op_finished) begin
            done_q         <= 1'b1;
            rd_count_q     <= wptr_q + {7'd0, cap_en};
            app_burst_op_q <= 1'b0;
            state_q        <= S_DONE;
          end else if (tmo_hit) begin
            // Abort: the controller never closed the operation.
            err_q          <= 1'b1;
            done_q         <= 1'b1;
            rd_count_q     <= wptr_q + {7'd0, cap_en};
            app_burst_op_q <= 1'b0;
            cmd_ready_q    <= app_ctrlr_good;
            state_q        <= app_ctrlr_good ? S_IDLE : S_WAIT_GOOD;
          end
        end
        S_DONE: begin
          cmd_ready_q <= app_ctrlr_good;
          state_q     <= app_ctrlr_good ? S_IDLE : S_WAIT_GOOD;
        end
        default: begin
          state_q     <= S_WAIT_GOOD;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer storage has no reset; reads return pre-write data on a same-index collision.
  always_ff @(posedge clk_100) begin
    if (cap_en) mem[wptr_q[AW-1:0]] <= app_data_out;
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) buf_word_q <= '0;
    else          buf_word_q <= mem[buf_idx];
  end

  assign app_addr     = app_addr_q;
  assign app_data_in  = app_data_in_q;
  assign app_rd       = app_rd_q;
  assign app_wr       = app_wr_q;
  assign app_ub       = app_ub_q;
  assign app_lb       = app_lb_q;
  assign app_burst_op = app_burst_op_q;
  assign cmd_ready    = cmd_ready_q;
  assign buf_word     = buf_word_q;
  assign rd_count     = rd_count_q;
  assign done         = done_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_psram_line_master.sv
// Bench for psram_line_master: a small controller model drives the app_* side,
// captured read words are scoreboarded and read back through the line buffer port.
module tb_psram_line_master;
  localparam int TIMEOUT = 1023;

  logic        clk_100 = 1'b0;
  logic        reset_n;
  logic        app_ctrlr_good, app_op_begun, app_data_ok, op_finished;
  logic [15:0] app_data_out;
  logic [22:0] app_addr;
  logic [15:0] app_data_in;
  logic        app_rd, app_wr, app_ub, app_lb, app_burst_op;
  logic        cmd_valid, cmd_ready, cmd_rd, cmd_ub, cmd_lb;
  logic [22:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] cmd_wdata;
  logic [6:0]  buf_idx;
  logic [15:0] buf_word;
  logic [7:0]  rd_count;
  logic        done, err;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  logic [15:0] exp_q[$];

  // clock / reset block
  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc_n <= cyc_n + 1;

  psram_line_master #(.BUF_DEPTH(128), .TIMEOUT(TIMEOUT)) dut (
    .clk_100(clk_100), .reset_n(reset_n), .app_ctrlr_good(app_ctrlr_good),
    .app_op_begun(app_op_begun), .app_data_ok(app_data_ok), .op_finished(op_finished),
    .app_data_out(app_data_out), .app_addr(app_addr), .app_data_in(app_data_in),
    .app_rd(app_rd), .app_wr(app_wr), .app_ub(app_ub), .app_lb(app_lb),
    .app_burst_op(app_burst_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .cmd_ub(cmd_ub), .cmd_lb(cmd_lb), .buf_idx(buf_idx), .buf_word(buf_word),
    .rd_count(rd_count), .done(done), .err(err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic [22:0] addr, input logic [7:0] len,
                       input logic [15:0] wd, input logic ub, input logic lb);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk_100);
      t++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_len = len;
    cmd_wdata = wd; cmd_ub = ub; cmd_lb = lb;
    @(negedge clk_100);
    cmd_valid = 1'b0;
  endtask

  // Controller model. n_words are driven (plus `extra` beyond the burst); finish=0 never
  // closes the operation; rst_word >= 0 asserts reset just before that word.
  task automatic ctrl_op(input logic rd, input int len_eff, input int n_words, input int extra,
                         input bit finish, input int begun_dly, input logic [22:0] addr,
                         input int rst_word, input int data_base);
    int t = 0;
    int t0;
    int exp_cnt;
    logic [15:0] val;
    while (!(app_rd || app_wr) && t < 20) begin
      @(negedge clk_100);
      t++;
    end
    check("req_strobe", {app_rd, app_wr}, rd ? 2'b10 : 2'b01);
    check("req_addr", app_addr, addr);
    check("req_burst", app_burst_op, 0);
    repeat (begun_dly) begin
      @(negedge clk_100);
      check("strobe_held", {app_rd, app_wr}, rd ? 2'b10 : 2'b01);
    end
    app_op_begun = 1'b1;
    t0 = cyc_n;
    @(negedge clk_100);
    app_op_begun = 1'b0;
    check("strobe_drop", {app_rd, app_wr}, 0);
    check("burst_after_begun", app_burst_op, rd && (len_eff > 1));
    exp_cnt = 0;
    if (rd) begin
      for (int w = 0; w < n_words + extra; w++) begin
        if (w == rst_word) begin
          reset_n = 1'b0;
          app_data_ok = 1'b0;
          #1;
          check("rst_rd", app_rd, 0);
          check("rst_burst", app_burst_op, 0);
          check("rst_state", dbg_state, 0);
          return;
        end
        val = (data_base >= 0) ? 16'(data_base + w) : 16'($urandom_range(0, 65535));
        if (w < 128) begin
          exp_q.push_back(val);
          exp_cnt++;
        end
        app_data_ok = 1'b1;
        app_data_out = val;
        @(negedge clk_100);
        if (w < len_eff)
          check($sformatf("burst_w%0d", w), app_burst_op, (w < len_eff - 1));
        @(negedge clk_100);
        app_data_ok = 1'b0;
        app_data_out = 16'h0;
        @(negedge clk_100);
      end
    end else begin
      repeat (2) begin
        @(negedge clk_100);
        check("wr_burst", app_burst_op, 0);
      end
    end
    if (finish) begin
      op_finished = 1'b1;
      @(negedge clk_100);
      op_finished = 1'b0;
      check("done_pulse", done, 1);
      check("rd_count", rd_count, exp_cnt);
      check("err_clear", err, 0);
      @(negedge clk_100);
      check("done_width", done, 0);
    end else begin
      while (!done && (cyc_n - t0) < TIMEOUT + 20) @(negedge clk_100);
      check("tmo_done", done, 1);
      check("tmo_latency", cyc_n - t0, TIMEOUT + 1);
      check("tmo_err", err, 1);
      check("tmo_burst", app_burst_op, 0);
    end
  endtask

  task automatic check_buf(input int n);
    for (int i = 0; i < n; i++) begin
      buf_idx = 7'(i);
      @(negedge clk_100);
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check($sformatf("buf_%0d", i), buf_word, exp_q.pop_front());
    end
    check("sb_leftover", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; app_ctrlr_good = 1'b0; app_op_begun = 1'b0; app_data_ok = 1'b0;
    op_finished = 1'b0; app_data_out = '0; cmd_valid = 1'b0; cmd_rd = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_wdata = '0; cmd_ub = 1'b0; cmd_lb = 1'b0; buf_idx = '0;
    repeat (3) @(negedge clk_100);
    check("rst_flags", {app_rd, app_wr, app_ub, app_lb, app_burst_op, cmd_ready, done, err}, 0);
    check("rst_addr", app_addr, 0);
    check("rst_wdata", app_data_in, 0);
    check("rst_buf_word", buf_word, 0);
    check("rst_rd_count", rd_count, 0);

    reset_n = 1'b1;
    repeat (3) @(negedge clk_100);
    check("nogood_ready", cmd_ready, 0);
    check("nogood_state", dbg_state, 0);
    app_ctrlr_good = 1'b1;
    @(negedge clk_100);
    check("good_ready", cmd_ready, 1);
    check("good_app_idle", {app_rd, app_wr, app_ub, app_lb, app_burst_op}, 0);

    // single write, begun 3 cycles after request
    issue(1'b0, 23'h12345, 8'd0, 16'hBEEF, 1'b1, 1'b0);
    check("wr_data", app_data_in, 16'hBEEF);
    check("wr_bytes", {app_ub, app_lb}, 2'b10);
    ctrl_op(1'b0, 1, 0, 0, 1'b1, 3, 23'h12345, -1, 0);

    // read of 4 with known data
    issue(1'b1, 23'h100, 8'd4, 16'h0, 1'b0, 1'b0);
    check("rd_bytes", {app_ub, app_lb}, 2'b11);
    ctrl_op(1'b1, 4, 4, 0, 1'b1, 1, 23'h100, -1, 'hA0);
    check_buf(4);

    // len 0 -> one word
    issue(1'b1, 23'h200, 8'd0, 16'h0, 1'b0, 1'b0);
    ctrl_op(1'b1, 1, 1, 0, 1'b1, 0, 23'h200, -1, -1);
    check_buf(1);

    // len 200 -> clipped to 128, two extra words must be dropped
    issue(1'b1, 23'h300, 8'd200, 16'h0, 1'b0, 1'b0);
    ctrl_op(1'b1, 128, 128, 2, 1'b1, 0, 23'h300, -1, -1);
    check_buf(128);

    // early op_finished after 3 of 8 words
    issue(1'b1, 23'h400, 8'd8, 16'h0, 1'b0, 1'b0);
    ctrl_op(1'b1, 8, 3, 0, 1'b1, 2, 23'h400, -1, -1);
    check_buf(3);

    // timeout on a write, then the next command clears err
    issue(1'b0, 23'h500, 8'd0, 16'h1234, 1'b1, 1'b1);
    ctrl_op(1'b0, 1, 0, 0, 1'b0, 1, 23'h500, -1, 0);
    issue(1'b0, 23'h600, 8'd0, 16'h5678, 1'b0, 1'b1);
    check("err_cleared", err, 0);
    check("wr2_bytes", {app_ub, app_lb}, 2'b01);
    ctrl_op(1'b0, 1, 0, 0, 1'b1, 0, 23'h600, -1, 0);

    // controller-good drop while idle
    app_ctrlr_good = 1'b0;
    @(negedge clk_100);
    check("gooddrop_ready", cmd_ready, 0);
    check("gooddrop_state", dbg_state, 0);
    app_ctrlr_good = 1'b1;
    @(negedge clk_100);
    check("goodback_ready", cmd_ready, 1);

    // reset mid-burst at word 2, then a fresh len=2 read
    issue(1'b1, 23'h700, 8'd8, 16'h0, 1'b0, 1'b0);
    ctrl_op(1'b1, 8, 8, 0, 1'b1, 0, 23'h700, 2, -1);
    exp_q.delete();
    @(negedge clk_100);
    reset_n = 1'b1;
    #1;
    check("post_rst_state", dbg_state, 0);
    @(negedge clk_100);
    issue(1'b1, 23'h800, 8'd2, 16'h0, 1'b0, 1'b0);
    ctrl_op(1'b1, 2, 2, 0, 1'b1, 1, 23'h800, -1, -1);
    check_buf(2);

    repeat (2) @(negedge clk_100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
